demux_dff_router: RTL and testbench

DEMUX_DFF_ROUTER -- requirements
Module: demux_dff_router

---
 rtl/demux_dff_pkg.sv | 14 +
 rtl/demux_dff_router_chan_fifo.sv | 72 +++++++
 rtl/demux_dff_router.sv | 92 +++++++++
 tb/tb_demux_dff_router.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux_dff_pkg.sv
// Shared constants for the two-channel demux router.
// This package holds the channel indices, the beat-counter width and the FIFO index-width helper.
package demux_dff_pkg;

    localparam int CH0   = 0;
    localparam int CH1   = 1;
    localparam int CNT_W = 16;

    // Guard against a zero-width pointer if a degenerate depth is ever used.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/demux_dff_router_chan_fifo.sv
// Single-channel FIFO: circular storage with modulo-DEPTH pointers.
// A separate occupancy counter tells full apart from empty.
module chan_fifo
    import demux_dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is deliberately unreset; the head is ignored while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/demux_dff_router.sv
// Two-way demux router: each input beat goes into a per-channel FIFO picked by Sel.
// Each channel has its own wrapping count of accepted beats.
module demux_dff_router
    import demux_dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Sel,
    input  logic             In_valid,
    input  logic [WIDTH-1:0] In_data,
    output logic             In_ready,
    output logic             Q0_valid,
    output logic [WIDTH-1:0] Q0_data,
    input  logic             Q0_ready,
    output logic             Q1_valid,
    output logic [WIDTH-1:0] Q1_data,
    input  logic             Q1_ready,
    output logic [15:0]      Cnt0,
    output logic [15:0]      Cnt1
);

    logic             full0, full1;
    logic             empty0, empty1;
    logic             sel_ch0;
    logic             accept;
    logic             push0, push1;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    assign sel_ch0 = (Sel == 1'(CH0));

    // A full channel refuses a beat even if it pops on the same edge.
    assign In_ready = sel_ch0 ? !full0 : !full1;
    assign accept   = In_valid && In_ready;
    assign push0    = accept && sel_ch0;
    assign push1    = accept && !sel_ch0;

    chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk_i       (Clock),
        .rst_n_i     (Resetn),
        .push_i      (push0),
        .push_data_i (In_data),
        .pop_i       (Q0_ready),
        .full_o      (full0),
        .empty_o     (empty0),
        .head_o      (Q0_data)
    );

    chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk_i       (Clock),
        .rst_n_i     (Resetn),
        .push_i      (push1),
        .push_data_i (In_data),
        .pop_i       (Q1_ready),
        .full_o      (full1),
        .empty_o     (empty1),
        .head_o      (Q1_data)
    );

    assign Q0_valid = !empty0;
    assign Q1_valid = !empty1;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0) cnt0_d = cnt0_q + CNT_W'(1);
        if (push1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign Cnt0 = cnt0_q;
    assign Cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux_dff_router.sv
// Directed and random bench for demux_dff_router, using queue-based per-channel expectations.
// Outputs are compared every falling edge, plus literal spot checks at key points.
module tb_demux_dff_router;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             Clock = 1'b0;
    logic             Resetn = 1'b0;
    logic             Sel = 1'b0;
    logic             In_valid = 1'b0;
    logic [WIDTH-1:0] In_data = '0;
    logic             In_ready;
    logic             Q0_valid, Q1_valid;
    logic [WIDTH-1:0] Q0_data, Q1_data;
    logic             Q0_ready = 1'b0;
    logic             Q1_ready = 1'b0;
    logic [15:0]      Cnt0, Cnt1;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [15:0]      m_cnt0 = '0;
    logic [15:0]      m_cnt1 = '0;

    demux_dff_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Sel      (Sel),
        .In_valid (In_valid),
        .In_data  (In_data),
        .In_ready (In_ready),
        .Q0_valid (Q0_valid),
        .Q0_data  (Q0_data),
        .Q0_ready (Q0_ready),
        .Q1_valid (Q1_valid),
        .Q1_data  (Q1_data),
        .Q1_ready (Q1_ready),
        .Cnt0     (Cnt0),
        .Cnt1     (Cnt1)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Model: FIFO semantics expressed directly as queues with a capacity limit.
    initial begin
        bit acc, p0, p1;
        forever begin
            @(posedge Clock or negedge Resetn);
            if (!Resetn) begin
                q0.delete();
                q1.delete();
                m_cnt0 = '0;
                m_cnt1 = '0;
            end else begin
                acc = In_valid && ((Sel ? q1.size() : q0.size()) < DEPTH);
                p0  = Q0_ready && (q0.size() > 0);
                p1  = Q1_ready && (q1.size() > 0);
                if (p0) void'(q0.pop_front());
                if (p1) void'(q1.pop_front());
                if (acc) begin
                    if (Sel) begin q1.push_back(In_data); m_cnt1 = m_cnt1 + 16'd1; end
                    else     begin q0.push_back(In_data); m_cnt0 = m_cnt0 + 16'd1; end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            chk("in_ready", In_ready, ((Sel ? q1.size() : q0.size()) < DEPTH));
            chk("q0_valid", Q0_valid, q0.size() > 0);
            chk("q1_valid", Q1_valid, q1.size() > 0);
            if (q0.size() > 0) chk("q0_data", Q0_data, q0[0]);
            if (q1.size() > 0) chk("q1_data", Q1_data, q1[0]);
            chk("cnt0", Cnt0, m_cnt0);
            chk("cnt1", Cnt1, m_cnt1);
        end
    end

    initial begin
        repeat (2) tick();
        Resetn = 1'b1;

        // Routing, with the first beat offered on the first edge after reset release.
        In_valid = 1'b1; Sel = 1'b0; In_data = 8'hA5;
        tick();
        chk("route_q0_valid", Q0_valid, 1);
        chk("route_q0_data", Q0_data, 8'hA5);
        chk("route_q1_empty", Q1_valid, 0);
        chk("route_cnt0", Cnt0, 1);
        Sel = 1'b1; In_data = 8'h3C;
        tick();
        In_valid = 1'b0;
        chk("route_q1_valid", Q1_valid, 1);
        chk("route_q1_data", Q1_data, 8'h3C);
        chk("route_q0_hold", Q0_data, 8'hA5);
        chk("route_cnt1", Cnt1, 1);

        // Asynchronous reset with two beats buffered.
        #3 Resetn = 1'b0;
        #1;
        chk("rst_q0_valid", Q0_valid, 0);
        chk("rst_q1_valid", Q1_valid, 0);
        chk("rst_cnt0", Cnt0, 0);
        chk("rst_cnt1", Cnt1, 0);
        chk("rst_in_ready", In_ready, 1);
        tick();
        Resetn = 1'b1;

        // Backpressure on channel 0.
        Q0_ready = 1'b0; In_valid = 1'b1; Sel = 1'b0; In_data = 8'h01;
        tick();
        In_data = 8'h02;
        tick();
        In_data = 8'h03;
        #1;
        chk("full_in_ready_sel0", In_ready, 0);
        In_valid = 1'b0; Sel = 1'b1;
        #1;
        chk("full_in_ready_sel1", In_ready, 1);
        Sel = 1'b0; Q0_ready = 1'b1;
        chk("drain_first", Q0_data, 8'h01);
        tick();
        chk("drain_second_valid", Q0_valid, 1);
        chk("drain_second", Q0_data, 8'h02);
        tick();
        chk("drain_empty", Q0_valid, 0);
        Q0_ready = 1'b0;

        // Push and pop of channel 1 on the same edge.
        Sel = 1'b1; In_valid = 1'b1; In_data = 8'h55; Q1_ready = 1'b0;
        tick();
        chk("simul_pre", Q1_data, 8'h55);
        In_data = 8'h77; Q1_ready = 1'b1;
        tick();
        In_valid = 1'b0;
        chk("simul_valid", Q1_valid, 1);
        chk("simul_head", Q1_data, 8'h77);
        tick();
        chk("simul_occ_one", Q1_valid, 0);
        Q1_ready = 1'b0;

        // Counter wrap: 65535 beats then one more.
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        Q0_ready = 1'b1; Sel = 1'b0; In_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            In_data = 8'(i);
            tick();
        end
        chk("wrap_preload", Cnt0, 16'hFFFF);
        In_data = 8'hEE;
        tick();
        In_valid = 1'b0;
        chk("wrap_cnt0", Cnt0, 16'h0000);
        chk("wrap_head_valid", Q0_valid, 1);
        chk("wrap_head", Q0_data, 8'hEE);
        tick();
        chk("wrap_drained", Q0_valid, 0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            Sel      = 1'($urandom);
            In_valid = 1'($urandom);
            In_data  = 8'($urandom);
            Q0_ready = 1'($urandom);
            Q1_ready = 1'($urandom);
            tick();
        end
        In_valid = 1'b0; Q0_ready = 1'b1; Q1_ready = 1'b1;
        repeat (4) tick();
        chk("final_q0_empty", Q0_valid, 0);
        chk("final_q1_empty", Q1_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
